// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with a valid/ready holding register.
// Define UART_RX_PARITY_EN to receive one parity bit per frame and report parity_err.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RxD,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             data_bits_8,
  input  logic             parity_odd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);
  localparam int PW = $clog2(OVERSAMPLE);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t           state_q;
  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [PW-1:0]    phase_q;
  logic [2:0]       bit_q;
  logic [7:0]       sh_q, data_q, word;
  logic             bits8_q, pend_q, valid_q, ferr_q, perr_q, ovr_q;
  logic             rxd, tick, half, full, accept, load;
`ifdef UART_RX_PARITY_EN
  logic             odd_q;
`endif
  assign rxd    = sync_q[1];
  assign tick   = cnt_q == div_q;
  assign half   = tick && phase_q == PW'(OVERSAMPLE/2 - 1);
  assign full   = tick && phase_q == PW'(OVERSAMPLE - 1);
  assign accept = valid_q && rx_ready;
  assign load   = state_q == STOP && full;
  // In 7-bit mode the character has only shifted down to bit 1.
  assign word   = bits8_q ? sh_q : {1'b0, sh_q[7:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      bits8_q <= 1'b1;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], RxD};
      cnt_q  <= tick ? '0 : cnt_q + DIV_W'(1);
      if (tick) phase_q <= full ? '0 : phase_q + PW'(1);
      if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (load) begin
        if (valid_q && !accept) ovr_q <= 1'b1;
        else begin
          valid_q <= 1'b1;
          data_q  <= word;
          ferr_q  <= !rxd;
          perr_q  <= pend_q;
        end
      end
      case (state_q)
        IDLE: if (!rxd) begin
          cnt_q   <= '0;
          phase_q <= '0;
          bit_q   <= '0;
          pend_q  <= 1'b0;
          div_q   <= baud_div;
          bits8_q <= data_bits_8;
`ifdef UART_RX_PARITY_EN
          odd_q   <= parity_odd;
`endif
          state_q <= START;
        end
        START: if (half) begin
          phase_q <= '0;
          state_q <= rxd ? IDLE : DATA;
        end
        DATA: if (full) begin
          sh_q  <= {rxd, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == (bits8_q ? 3'd7 : 3'd6)) state_q <= PARITY;
`else
          if (bit_q == (bits8_q ? 3'd7 : 3'd6)) state_q <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (full) begin
          pend_q  <= rxd != (^word ^ odd_q);
          state_q <= STOP;
        end
`endif
        STOP: if (full) state_q <= rxd ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rxd) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_parity;
  assign unused_parity = ^{parity_odd, perr_q};
  assign parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random frames against a frame-level model of the receiver.
module tb_uart_rx_core;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, RxD = 1'b1;
  logic        data_bits_8 = 1'b1, parity_odd = 1'b0, rx_ready = 1'b0;
  logic [15:0] baud_div = '0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, parity_err, overrun;
  int          total = 0, bad = 0, cyc = 0, rises = 0, rise_cyc = 0;
  logic        valid_d = 1'b0;
  logic [7:0]  m_data = '0;
  logic        m_valid = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;

  uart_rx_core #(.OVERSAMPLE(OS), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .RxD(RxD), .baud_div(baud_div),
    .data_bits_8(data_bits_8), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid && !valid_d) begin
      rises    <= rises + 1;
      rise_cyc <= cyc;
    end
    valid_d <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask(input logic [7:0] d, input bit b8);
    return b8 ? d : {1'b0, d[6:0]};
  endfunction

  function automatic bit good_par(input logic [7:0] d, input bit odd);
    return ^d ^ odd;
  endfunction

  task automatic m_load(input logic [7:0] d, input bit ferr, input bit perr);
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_data  = d;
      m_ferr  = ferr;
      m_perr  = perr;
    end
  endtask

  task automatic m_accept();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic cmp_all(input string t);
    check($sformatf("%s.valid", t), 32'(rx_valid), 32'(m_valid));
    check($sformatf("%s.data", t), 32'(rx_data), 32'(m_data));
    check($sformatf("%s.ferr", t), 32'(frame_err), 32'(m_ferr));
    check($sformatf("%s.perr", t), 32'(parity_err), 32'(m_perr));
    check($sformatf("%s.ovr", t), 32'(overrun), 32'(m_ovr));
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    m_accept();
    @(negedge clk);
  endtask

  // Drives one frame; config inputs are scrambled mid-frame to prove they were latched.
  task automatic send(input logic [7:0] d, input bit b8, input bit odd, input bit par,
                      input bit stop, input int div);
    int bl;
    bl = OS * (div + 1);
    baud_div = 16'(div); data_bits_8 = b8; parity_odd = odd;
    RxD = 1'b0;
    repeat (8) @(negedge clk);
    baud_div = 16'($urandom_range(0, 3)); data_bits_8 = 1'($urandom); parity_odd = 1'($urandom);
    repeat (bl - 8) @(negedge clk);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      RxD = d[i];
      repeat (bl) @(negedge clk);
    end
    if (PEN) begin
      RxD = par;
      repeat (bl) @(negedge clk);
    end
    RxD = stop;
    repeat (bl) @(negedge clk);
  endtask

  task automatic good_frame(input logic [7:0] d, input bit b8, input int div);
    send(d, b8, 1'b0, good_par(mask(d, b8), 1'b0), 1'b1, div);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    m_load(mask(d, b8), 1'b0, 1'b0);
  endtask

  task automatic rand_frame();
    logic [7:0] d, dd;
    bit b8, odd, par, stop;
    int div, mode;
    d = 8'($urandom); b8 = 1'($urandom); odd = 1'($urandom); par = 1'($urandom);
    stop = $urandom_range(0, 3) != 0; div = $urandom_range(0, 3); mode = $urandom_range(0, 2);
    dd = mask(d, b8);
    if (mode == 2) begin
      rx_ready = 1'b1;
      m_accept();
    end
    send(d, b8, odd, par, stop, div);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    m_load(dd, !stop, PEN && (par != good_par(dd, odd)));
    if (mode == 2) begin
      m_accept();
      rx_ready = 1'b0;
      @(negedge clk);
    end
    cmp_all("rand");
    if (mode == 1) begin
      pulse_ready();
      cmp_all("rand_acc");
    end
  endtask

  initial begin
    int t0, lat, base, r0;
    repeat (3) @(negedge clk);
    cmp_all("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    baud_div = 16'd53;
    r0 = rises;
    RxD = 1'b0;
    repeat (200) @(negedge clk);
    RxD = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_rises", 32'(rises - r0), 32'd0);

    t0 = cyc;
    good_frame(8'hA5, 1'b1, 53);
    lat  = rise_cyc - t0;
    base = (OS / 2 + OS * (8 + int'(PEN) + 1)) * 54;
    check("latency", 32'((lat >= base + 1 && lat <= base + 4) ? base + 3 : lat), 32'(base + 3));
    check("a5_data", 32'(rx_data), 32'h A5);
    cmp_all("a5");

    pulse_ready();
    send(8'h11, 1'b1, 1'b0, good_par(8'h11, 1'b0), 1'b1, 1);
    m_load(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, good_par(8'h22, 1'b0), 1'b1, 1);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    m_load(8'h22, 1'b0, 1'b0);
    check("b2b_ovr", 32'(overrun), 32'd1);
    cmp_all("b2b");
    pulse_ready();
    cmp_all("b2b_acc");

    r0 = rises;
    send(8'h3C, 1'b1, 1'b0, good_par(8'h3C, 1'b0), 1'b0, 3);
    repeat (2000) @(negedge clk);
    check("break_rises", 32'(rises - r0), 32'd1);
    m_load(8'h3C, 1'b1, 1'b0);
    cmp_all("break");
    RxD = 1'b1;
    repeat (300) @(negedge clk);
    check("break_after", 32'(rises - r0), 32'd1);
    pulse_ready();

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    m_load(8'h07, 1'b0, 1'b1);
    check("par_bad", 32'(parity_err), 32'd1);
    cmp_all("par1");
    pulse_ready();
    send(8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    m_load(8'h07, 1'b0, 1'b0);
    check("par_good", 32'(parity_err), 32'd0);
    cmp_all("par0");
    pulse_ready();
`endif

    good_frame(8'h66, 1'b1, 0);
    cmp_all("pre_rst");
    baud_div = 16'd3; data_bits_8 = 1'b1;
    RxD = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RxD = 1'b1;
      repeat (64) @(negedge clk);
    end
    repeat (32) @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
    cmp_all("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    good_frame(8'h5A, 1'b1, 3);
    cmp_all("post_rst");

    for (int n = 0; n < 24; n++) rand_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
